// File: rtl/hnf_pkg.sv
// Shared HN-F definitions: parameter defaults, CHI snoop-response Resp
// encodings, the snoop opcode and the snoop sequencer state type.
package hnf_pkg;

    localparam int DEF_NUM_RN   = 4;
    localparam int DEF_ADDR_W   = 48;
    localparam int DEF_TXNID_W  = 12;
    localparam int DEF_NODEID_W = 7;
    localparam int DEF_STATE_W  = 3;

    // Resp[1:0] is the line state left at the snooped RN-F; Resp[2] is PassDirty.
    localparam logic [1:0] RESP_I      = 2'b00;
    localparam logic [1:0] RESP_SC     = 2'b01;
    localparam logic [1:0] RESP_UC     = 2'b10;
    localparam int         RESP_PD_BIT = 2;

    typedef enum logic {
        SNP_SHARED = 1'b0,
        SNP_UNIQUE = 1'b1
    } snp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } snp_state_e;

endpackage

// File: rtl/sf_pri_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   vec_i    - input vector
//   idx_o    - index of the lowest set bit (0 when vec_i is empty)
//   onehot_o - one-hot of the lowest set bit (0 when vec_i is empty)
module sf_pri_enc #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = vec_i & (~vec_i + N'(1));

endmodule

// File: rtl/sf_snp_ctrl.sv
// Snoop sequencer behind the HN-F snoop filter. Takes one request with its
// SF presence vector, snoops every present RN-F except the requester (one
// per cycle), collects the responses and returns a completion with the
// aggregated dirty status and the presence vector to write back.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   req_*               - request from POCQ/SF lookup (valid/ready)
//   snp_*               - outgoing snoop flit (valid/ready)
//   snprsp_*            - snoop responses, always accepted
//   done_*              - completion and SF writeback vector (valid/ready)
//   err_unexp_rsp       - same-cycle pulse on an unexpected response
//
//   state | meaning
//   IDLE  | ready for a request
//   SEND  | issuing snoops, lowest pending RN-F first
//   WAIT  | all snoops issued, collecting outstanding responses
//   DONE  | completion presented until accepted
module sf_snp_ctrl
    import hnf_pkg::*;
#(
    parameter int NUM_RN   = DEF_NUM_RN,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int TXNID_W  = DEF_TXNID_W,
    parameter int NODEID_W = DEF_NODEID_W,
    parameter int STATE_W  = DEF_STATE_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [TXNID_W-1:0]  req_txnid,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [NODEID_W-1:0] req_srcid,
    input  logic                req_unique,
    input  logic [NUM_RN-1:0]   req_rnf_vec,
    output logic                snp_valid,
    input  logic                snp_ready,
    output logic [NODEID_W-1:0] snp_tgtid,
    output logic [TXNID_W-1:0]  snp_txnid,
    output logic [ADDR_W-1:0]   snp_addr,
    output logic                snp_inv,
    input  logic                snprsp_valid,
    input  logic [NODEID_W-1:0] snprsp_srcid,
    input  logic [STATE_W-1:0]  snprsp_resp,
    output logic                done_valid,
    input  logic                done_ready,
    output logic [TXNID_W-1:0]  done_txnid,
    output logic                done_dirty,
    output logic [NUM_RN-1:0]   done_rnf_vec,
    output logic                err_unexp_rsp
);

    localparam int CNT_W = $clog2(NUM_RN + 1);
    localparam int IDX_W = (NUM_RN > 1) ? $clog2(NUM_RN) : 1;

    snp_state_e          state_q, state_d;
    snp_op_e             op_q, op_d;
    logic [TXNID_W-1:0]  txnid_q, txnid_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_RN-1:0]   req_oh_q, req_oh_d;   // requester bit, 0 if not an RN-F
    logic [NUM_RN-1:0]   pend_q, pend_d;
    logic [NUM_RN-1:0]   issued_q, issued_d;
    logic [NUM_RN-1:0]   rsp_seen_q, rsp_seen_d;
    logic [NUM_RN-1:0]   keep_q, keep_d;
    logic                dirty_q, dirty_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [IDX_W-1:0]    enc_idx;
    logic [NUM_RN-1:0]   enc_oh;
    logic [NUM_RN-1:0]   src_oh;
    logic [NUM_RN-1:0]   rsp_oh;
    logic                snp_fire;
    logic                rsp_ok;

    sf_pri_enc #(.N(NUM_RN), .IDX_W(IDX_W)) u_pri_enc (
        .vec_i    (pend_q),
        .idx_o    (enc_idx),
        .onehot_o (enc_oh)
    );

    // Node IDs at or above NUM_RN map to no presence bit at all.
    assign src_oh = (req_srcid < NODEID_W'(NUM_RN)) ? (NUM_RN'(1) << req_srcid) : '0;
    assign rsp_oh = (snprsp_srcid < NODEID_W'(NUM_RN)) ? (NUM_RN'(1) << snprsp_srcid) : '0;

    assign snp_fire = snp_valid && snp_ready;
    assign rsp_ok   = snprsp_valid && ((state_q == ST_SEND) || (state_q == ST_WAIT))
                      && ((rsp_oh & issued_q & ~rsp_seen_q) != '0);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        txnid_d    = txnid_q;
        addr_d     = addr_q;
        req_oh_d   = req_oh_q;
        pend_d     = pend_q;
        issued_d   = issued_q;
        rsp_seen_d = rsp_seen_q;
        keep_d     = keep_q;
        dirty_d    = dirty_q;
        req_ready  = 1'b0;
        snp_valid  = 1'b0;
        done_valid = 1'b0;
        err_unexp_rsp = snprsp_valid && !rsp_ok;

        // Issue and response in the same cycle cancel out.
        cnt_d = cnt_q + CNT_W'(snp_fire) - CNT_W'(rsp_ok);

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    txnid_d    = req_txnid;
                    addr_d     = req_addr;
                    op_d       = req_unique ? SNP_UNIQUE : SNP_SHARED;
                    req_oh_d   = src_oh;
                    pend_d     = req_rnf_vec & ~src_oh;
                    issued_d   = '0;
                    rsp_seen_d = '0;
                    keep_d     = '0;
                    dirty_d    = 1'b0;
                    cnt_d      = '0;
                    state_d    = ((req_rnf_vec & ~src_oh) != '0) ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                snp_valid = 1'b1;
                if (snp_ready) begin
                    pend_d   = pend_q & ~enc_oh;
                    issued_d = issued_q | enc_oh;
                    if ((pend_q & ~enc_oh) == '0) state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_d == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_valid = 1'b1;
                if (done_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (rsp_ok) begin
            rsp_seen_d = rsp_seen_q | rsp_oh;
            dirty_d    = dirty_q | snprsp_resp[RESP_PD_BIT];
            // A shared snoop leaves the line with RN-Fs that report a valid state.
            if ((snprsp_resp[1:0] != RESP_I) && (op_q == SNP_SHARED))
                keep_d = keep_q | rsp_oh;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= SNP_SHARED;
            txnid_q    <= '0;
            addr_q     <= '0;
            req_oh_q   <= '0;
            pend_q     <= '0;
            issued_q   <= '0;
            rsp_seen_q <= '0;
            keep_q     <= '0;
            dirty_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            txnid_q    <= txnid_d;
            addr_q     <= addr_d;
            req_oh_q   <= req_oh_d;
            pend_q     <= pend_d;
            issued_q   <= issued_d;
            rsp_seen_q <= rsp_seen_d;
            keep_q     <= keep_d;
            dirty_q    <= dirty_d;
            cnt_q      <= cnt_d;
        end
    end

    assign snp_tgtid    = NODEID_W'(enc_idx);
    assign snp_txnid    = txnid_q;
    assign snp_addr     = addr_q;
    assign snp_inv      = (op_q == SNP_UNIQUE);
    assign done_txnid   = txnid_q;
    assign done_dirty   = (state_q == ST_DONE) && dirty_q;
    assign done_rnf_vec = (state_q != ST_DONE) ? '0 :
                          (op_q == SNP_UNIQUE) ? req_oh_q : (keep_q | req_oh_q);

endmodule

// File: tb/tb_sf_snp_ctrl.sv
module tb_sf_snp_ctrl;

    localparam int NUM_RN   = 4;
    localparam int ADDR_W   = 48;
    localparam int TXNID_W  = 12;
    localparam int NODEID_W = 7;
    localparam int STATE_W  = 3;

    localparam logic [2:0] R_I  = 3'b000;
    localparam logic [2:0] R_SC = 3'b001;
    localparam logic [2:0] R_UC = 3'b010;
    localparam logic [2:0] R_UD_PD = 3'b110;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [TXNID_W-1:0]  req_txnid = '0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [NODEID_W-1:0] req_srcid = '0;
    logic                req_unique = 1'b0;
    logic [NUM_RN-1:0]   req_rnf_vec = '0;
    logic                snp_valid;
    logic                snp_ready = 1'b1;
    logic [NODEID_W-1:0] snp_tgtid;
    logic [TXNID_W-1:0]  snp_txnid;
    logic [ADDR_W-1:0]   snp_addr;
    logic                snp_inv;
    logic                snprsp_valid = 1'b0;
    logic [NODEID_W-1:0] snprsp_srcid = '0;
    logic [STATE_W-1:0]  snprsp_resp = '0;
    logic                done_valid;
    logic                done_ready = 1'b0;
    logic [TXNID_W-1:0]  done_txnid;
    logic                done_dirty;
    logic [NUM_RN-1:0]   done_rnf_vec;
    logic                err_unexp_rsp;

    int n_checks = 0;
    int n_errors = 0;

    sf_snp_ctrl #(
        .NUM_RN(NUM_RN), .ADDR_W(ADDR_W), .TXNID_W(TXNID_W),
        .NODEID_W(NODEID_W), .STATE_W(STATE_W)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_txnid(req_txnid),
        .req_addr(req_addr), .req_srcid(req_srcid), .req_unique(req_unique),
        .req_rnf_vec(req_rnf_vec),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_tgtid(snp_tgtid),
        .snp_txnid(snp_txnid), .snp_addr(snp_addr), .snp_inv(snp_inv),
        .snprsp_valid(snprsp_valid), .snprsp_srcid(snprsp_srcid), .snprsp_resp(snprsp_resp),
        .done_valid(done_valid), .done_ready(done_ready), .done_txnid(done_txnid),
        .done_dirty(done_dirty), .done_rnf_vec(done_rnf_vec),
        .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Tracks the open transaction as: RN-Fs still to snoop (in order), the
    // sets snooped and answered, and whether the completion is due.
    bit                  m_active = 1'b0;
    bit                  m_done = 1'b0;
    int                  m_targets[$];
    bit [NUM_RN-1:0]     m_sent, m_got, m_keep;
    bit                  m_dirty, m_unique;
    int                  m_src;
    logic [TXNID_W-1:0]  m_txnid;
    logic [ADDR_W-1:0]   m_addr;

    function automatic bit m_rsp_legal(input int id);
        return m_active && !m_done && id < NUM_RN && m_sent[id] && !m_got[id];
    endfunction

    function automatic logic [NUM_RN-1:0] m_done_vec();
        logic [NUM_RN-1:0] rq;
        rq = '0;
        if (m_src < NUM_RN) rq[m_src] = 1'b1;
        return m_unique ? rq : (m_keep | rq);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_active = 1'b0;
            m_done = 1'b0;
            m_targets.delete();
        end else if (!m_active) begin
            if (req_valid) begin
                m_active = 1'b1;
                m_src = int'(req_srcid);
                m_unique = req_unique;
                m_txnid = req_txnid;
                m_addr = req_addr;
                m_sent = '0; m_got = '0; m_keep = '0; m_dirty = 1'b0;
                m_targets.delete();
                for (int i = 0; i < NUM_RN; i++)
                    if (req_rnf_vec[i] && i != m_src) m_targets.push_back(i);
                m_done = (m_targets.size() == 0);
            end
        end else if (m_done) begin
            if (done_ready) begin
                m_active = 1'b0;
                m_done = 1'b0;
            end
        end else begin
            if (snprsp_valid && m_rsp_legal(int'(snprsp_srcid))) begin
                m_got[snprsp_srcid] = 1'b1;
                if (snprsp_resp[2]) m_dirty = 1'b1;
                if (snprsp_resp[1:0] != 2'b00 && !m_unique) m_keep[snprsp_srcid] = 1'b1;
            end
            if (m_targets.size() > 0 && snp_ready) m_sent[m_targets.pop_front()] = 1'b1;
            if (m_targets.size() == 0 && $countones(m_sent & ~m_got) == 0) m_done = 1'b1;
        end
    end

    always @(negedge clock) begin
        bit exp_snp;
        bit exp_done;
        if (!reset) begin
            exp_snp  = m_active && !m_done && m_targets.size() > 0;
            exp_done = m_active && m_done;
            check("req_ready", 64'(req_ready), 64'(!m_active));
            check("snp_valid", 64'(snp_valid), 64'(exp_snp));
            if (exp_snp) begin
                check("snp_tgtid", 64'(snp_tgtid), 64'(m_targets[0]));
                check("snp_inv",   64'(snp_inv),   64'(m_unique));
                check("snp_txnid", 64'(snp_txnid), 64'(m_txnid));
                check("snp_addr",  64'(snp_addr),  64'(m_addr));
            end
            check("done_valid", 64'(done_valid), 64'(exp_done));
            if (exp_done) begin
                check("done_txnid",   64'(done_txnid),   64'(m_txnid));
                check("done_dirty",   64'(done_dirty),   64'(m_dirty));
                check("done_rnf_vec", 64'(done_rnf_vec), 64'(m_done_vec()));
            end
            check("err_unexp_rsp", 64'(err_unexp_rsp),
                  64'(snprsp_valid && !m_rsp_legal(int'(snprsp_srcid))));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input int src, input logic [NUM_RN-1:0] vec, input bit uniq,
                          input logic [TXNID_W-1:0] tid, input logic [ADDR_W-1:0] addr);
        req_srcid = NODEID_W'(src);
        req_rnf_vec = vec;
        req_unique = uniq;
        req_txnid = tid;
        req_addr = addr;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) tick();
        check("req_accept_timeout", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_rsp(input int id, input logic [2:0] resp, output logic err);
        snprsp_srcid = NODEID_W'(id);
        snprsp_resp = resp;
        snprsp_valid = 1'b1;
        #1;
        err = err_unexp_rsp;
        @(posedge clock);
        #1;
        snprsp_valid = 1'b0;
    endtask

    task automatic ack_done();
        int n;
        n = 0;
        while (!done_valid && n < 50) begin
            tick();
            n++;
        end
        check("done_timeout", 64'(done_valid), 64'(1));
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    initial begin
        logic e;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_req_ready",  64'(req_ready),     64'(1));
        check("rst_snp_valid",  64'(snp_valid),     64'(0));
        check("rst_done_valid", 64'(done_valid),    64'(0));
        check("rst_done_vec",   64'(done_rnf_vec),  64'(0));
        check("rst_err",        64'(err_unexp_rsp), 64'(0));

        // 1: shared, requester is the only holder
        do_req(2, 4'b0100, 1'b0, 12'h011, 48'h1000);
        check("t1_done_lat", 64'(done_valid),   64'(1));
        check("t1_vec",      64'(done_rnf_vec), 64'(4'b0100));
        check("t1_dirty",    64'(done_dirty),   64'(0));
        check("t1_req_busy", 64'(req_ready),    64'(0));
        ack_done();

        // 2: unique, three sharers, last one passes dirty
        do_req(0, 4'b1110, 1'b1, 12'h022, 48'h2040);
        check("t2_snp1", 64'(snp_tgtid), 64'(1));
        check("t2_inv",  64'(snp_inv),   64'(1));
        tick();
        check("t2_snp2", 64'(snp_tgtid), 64'(2));
        tick();
        check("t2_snp3", 64'(snp_tgtid), 64'(3));
        tick();
        check("t2_snp_end", 64'(snp_valid), 64'(0));
        send_rsp(1, R_I, e);
        send_rsp(2, R_I, e);
        send_rsp(3, R_UD_PD, e);
        check("t2_done_lat", 64'(done_valid),   64'(1));
        check("t2_vec",      64'(done_rnf_vec), 64'(4'b0001));
        check("t2_dirty",    64'(done_dirty),   64'(1));
        ack_done();

        // 3: shared with snoop backpressure
        snp_ready = 1'b0;
        do_req(3, 4'b0011, 1'b0, 12'h033, 48'h3080);
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_valid", 64'(snp_valid), 64'(1));
            check("t3_stall_tgt",   64'(snp_tgtid), 64'(0));
            tick();
        end
        snp_ready = 1'b1;
        tick();
        check("t3_snp2", 64'(snp_tgtid), 64'(1));
        tick();
        send_rsp(0, R_SC, e);
        send_rsp(1, R_I, e);
        check("t3_vec",   64'(done_rnf_vec), 64'(4'b1001));
        check("t3_dirty", 64'(done_dirty),   64'(0));
        ack_done();

        // 4: response to RN1 in the cycle RN2's snoop fires
        do_req(0, 4'b0110, 1'b0, 12'h044, 48'h40C0);
        tick();
        check("t4_snp2", 64'(snp_tgtid), 64'(2));
        send_rsp(1, R_UC, e);
        check("t4_err", 64'(e), 64'(0));
        tick();
        tick();
        check("t4_not_done", 64'(done_valid), 64'(0));
        send_rsp(2, R_I, e);
        check("t4_done", 64'(done_valid),   64'(1));
        check("t4_vec",  64'(done_rnf_vec), 64'(4'b0011));
        ack_done();

        // 5: unexpected responses
        do_req(0, 4'b0110, 1'b0, 12'h055, 48'h5100);
        tick();
        tick();
        send_rsp(1, R_I, e);
        check("t5_ok1", 64'(e), 64'(0));
        send_rsp(3, R_SC, e);
        check("t5_unsnooped", 64'(e), 64'(1));
        send_rsp(1, R_I, e);
        check("t5_dup", 64'(e), 64'(1));
        check("t5_not_done", 64'(done_valid), 64'(0));
        send_rsp(2, R_SC, e);
        check("t5_ok2",  64'(e),            64'(0));
        check("t5_done", 64'(done_valid),   64'(1));
        check("t5_vec",  64'(done_rnf_vec), 64'(4'b0101));
        ack_done();

        // 6: reset in WAIT with two responses outstanding
        do_req(0, 4'b1110, 1'b0, 12'h066, 48'h6140);
        tick();
        tick();
        tick();
        send_rsp(1, R_SC, e);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_req_ready", 64'(req_ready), 64'(1));
        check("t6_snp_valid", 64'(snp_valid), 64'(0));
        send_rsp(2, R_I, e);
        check("t6_stale2", 64'(e), 64'(1));
        send_rsp(3, R_I, e);
        check("t6_stale3", 64'(e), 64'(1));
        for (int i = 0; i < 3; i++) begin
            check("t6_no_done", 64'(done_valid), 64'(0));
            tick();
        end

        // 7: requester ID outside the RN-F range, response from a bogus ID
        do_req(5, 4'b0001, 1'b0, 12'h077, 48'h7180);
        check("t7_snp0", 64'(snp_tgtid), 64'(0));
        tick();
        send_rsp(9, R_SC, e);
        check("t7_bogus", 64'(e), 64'(1));
        send_rsp(0, R_SC, e);
        check("t7_ok",  64'(e),            64'(0));
        check("t7_vec", 64'(done_rnf_vec), 64'(4'b0001));
        ack_done();

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
